// File: rtl/crc_frame_sequencer.sv
// Framing front-end for the parallel CRC core: streams full words through the core,
// finishes partial last words byte-serially and presents one finalised CRC per frame.
module crc_frame_sequencer #(
  parameter int DATA_BYTES = 8,
  parameter int CRC_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BYTES*8-1:0]       s_data,
  input  logic                          s_last,
  input  logic [$clog2(DATA_BYTES)-1:0] s_nbytes,
  input  logic [CRC_WIDTH-1:0]          cfg_init,
  input  logic [CRC_WIDTH-1:0]          cfg_poly,
  input  logic                          cfg_reflect_in,
  input  logic                          cfg_reflect_out,
  input  logic [CRC_WIDTH-1:0]          cfg_xor_out,
  output logic                          core_enable,
  output logic [DATA_BYTES*8-1:0]       core_data,
  output logic [CRC_WIDTH-1:0]          core_crc_in,
  output logic [CRC_WIDTH-1:0]          core_poly,
  output logic                          core_reflect_in,
  output logic                          core_reflect_out,
  output logic [CRC_WIDTH-1:0]          core_xor_out,
  input  logic [CRC_WIDTH-1:0]          core_crc_out,
  output logic                          crc_valid,
  input  logic                          crc_ready,
  output logic [CRC_WIDTH-1:0]          crc_result
);
  localparam int DW  = DATA_BYTES * 8;
  localparam int NBW = $clog2(DATA_BYTES);

  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_TAIL, ST_DONE} state_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] bitrev_crc(input logic [CRC_WIDTH-1:0] x);
    logic [CRC_WIDTH-1:0] r;
    for (int i = 0; i < CRC_WIDTH; i++) r[i] = x[CRC_WIDTH-1-i];
    return r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] run,
                                                    input logic [7:0] b,
                                                    input logic [CRC_WIDTH-1:0] poly);
    logic [CRC_WIDTH-1:0] r;
    r = run ^ {b, {(CRC_WIDTH-8){1'b0}}};
    for (int i = 0; i < 8; i++) r = r[CRC_WIDTH-1] ? ((r << 1) ^ poly) : (r << 1);
    return r;
  endfunction

  state_t                 state_r, state_s;
  logic                   s_ready_r, crc_valid_r;
  logic [CRC_WIDTH-1:0]   crc_result_r;
  logic [CRC_WIDTH-1:0]   poly_r, xor_out_r;
  logic                   refl_in_r, refl_out_r;
  logic [DW-1:0]          tail_data_r;
  logic [NBW-1:0]         tail_cnt_r;
  logic [CRC_WIDTH-1:0]   tail_run_r;
  logic                   accept_s, full_s, tail_last_s;
  logic [7:0]             tail_byte_s;
  logic [CRC_WIDTH-1:0]   tail_next_s;

  function automatic logic [CRC_WIDTH-1:0] fin(input logic [CRC_WIDTH-1:0] x,
                                               input logic [CRC_WIDTH-1:0] xo,
                                               input logic ro);
    return ro ? bitrev_crc(x ^ xo) : (x ^ xo);
  endfunction

  assign accept_s    = s_valid & s_ready_r;
  assign full_s      = ~s_last | (s_nbytes == {NBW{1'b0}});
  assign tail_last_s = (tail_cnt_r == NBW'(1));
  assign tail_byte_s = refl_in_r ? bitrev8(tail_data_r[DW-1 -: 8]) : tail_data_r[DW-1 -: 8];
  assign tail_next_s = crc_byte(tail_run_r, tail_byte_s, poly_r);

  // The first word of a frame is hashed on the same edge that latches cfg,
  // so the core must see the live cfg while idle.
  assign core_enable      = accept_s & full_s;
  assign core_data        = s_data;
  assign core_crc_in      = (state_r == ST_IDLE) ? cfg_init : core_crc_out;
  assign core_poly        = (state_r == ST_IDLE) ? cfg_poly : poly_r;
  assign core_reflect_in  = (state_r == ST_IDLE) ? cfg_reflect_in : refl_in_r;
  assign core_reflect_out = 1'b0;
  assign core_xor_out     = {CRC_WIDTH{1'b0}};

  assign s_ready    = s_ready_r;
  assign crc_valid  = crc_valid_r;
  assign crc_result = crc_result_r;

  // Next-state decode for the frame FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (accept_s) begin
          if (full_s) state_s = s_last ? ST_FLUSH : ST_RUN;
          else        state_s = ST_TAIL;
        end else begin
          state_s = state_r;
        end
      end
      ST_FLUSH: state_s = ST_DONE;
      ST_TAIL: begin
        if (tail_last_s) state_s = ST_DONE;
        else             state_s = ST_TAIL;
      end
      ST_DONE: begin
        if (crc_ready) state_s = ST_IDLE;
        else           state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r     <= ST_IDLE;
      s_ready_r   <= 1'b1;
      crc_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      s_ready_r   <= (state_s == ST_IDLE) || (state_s == ST_RUN);
      crc_valid_r <= (state_s == ST_DONE);
    end
  end

  // Frame config latch, byte-serial tail engine and result register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      poly_r       <= {CRC_WIDTH{1'b0}};
      xor_out_r    <= {CRC_WIDTH{1'b0}};
      refl_in_r    <= 1'b0;
      refl_out_r   <= 1'b0;
      tail_data_r  <= {DW{1'b0}};
      tail_cnt_r   <= {NBW{1'b0}};
      tail_run_r   <= {CRC_WIDTH{1'b0}};
      crc_result_r <= {CRC_WIDTH{1'b0}};
    end else begin
      if ((state_r == ST_IDLE) && accept_s) begin
        poly_r     <= cfg_poly;
        xor_out_r  <= cfg_xor_out;
        refl_in_r  <= cfg_reflect_in;
        refl_out_r <= cfg_reflect_out;
      end
      if (accept_s && !full_s) begin
        tail_data_r <= s_data;
        tail_cnt_r  <= s_nbytes;
        tail_run_r  <= (state_r == ST_IDLE) ? cfg_init : core_crc_out;
      end else if (state_r == ST_TAIL) begin
        tail_data_r <= tail_data_r << 8;
        tail_cnt_r  <= tail_cnt_r - NBW'(1);
        tail_run_r  <= tail_next_s;
      end
      if (state_r == ST_FLUSH) begin
        crc_result_r <= fin(core_crc_out, xor_out_r, refl_out_r);
      end else if ((state_r == ST_TAIL) && tail_last_s) begin
        crc_result_r <= fin(tail_next_s, xor_out_r, refl_out_r);
      end
    end
  end

endmodule
